ex_mem_pipe_reg: RTL

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

---
 rtl/ex_mem_pipe_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer, valid/ready handshake,
// flush support and saturating stall/flush event counters.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regwrite_E,
  input  logic              memtoreg_E,
  input  logic              memwrite_E,
  input  logic [DATA_W-1:0] ALU_out_E,
  input  logic [DATA_W-1:0] write_data_E,
  input  logic [REG_W-1:0]  write_reg_E,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              regwrite_M,
  output logic              memtoreg_M,
  output logic              memwrite_M,
  output logic [DATA_W-1:0] ALU_out_M,
  output logic [DATA_W-1:0] write_data_M,
  output logic [REG_W-1:0]  write_reg_M,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } entry_t;

  entry_t main_q, skid_q, in_entry;
  logic   main_v, skid_v;
  logic   accept, fire;

  always_comb begin
    in_entry          = '0;
    // Register $0 is hardwired to zero, so never request a write to it.
    in_entry.regwrite = regwrite_E & (write_reg_E != '0);
    in_entry.memtoreg = memtoreg_E;
    in_entry.memwrite = memwrite_E;
    in_entry.alu      = ALU_out_E;
    in_entry.wdata    = write_data_E;
    in_entry.wreg     = write_reg_E;
  end

  assign in_ready  = ~rst & ~skid_v;
  assign out_valid = main_v;
  assign accept    = in_valid & in_ready & ~flush;
  assign fire      = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_v && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        if ((main_v || skid_v) && flush_cnt != '1)
          flush_cnt <= flush_cnt + 1'b1;
      end else if (fire) begin
        // Accept cannot coincide with a full skid, since in_ready is low then.
        if (skid_v) begin
          main_q <= skid_q;
          skid_v <= 1'b0;
        end else if (accept) begin
          main_q <= in_entry;
        end else begin
          main_v <= 1'b0;
        end
      end else if (accept) begin
        if (!main_v) begin
          main_q <= in_entry;
          main_v <= 1'b1;
        end else begin
          skid_q <= in_entry;
          skid_v <= 1'b1;
        end
      end
    end
  end

  // Control bits are qualified by valid; data fields hold their last value.
  assign regwrite_M   = main_v & main_q.regwrite;
  assign memtoreg_M   = main_v & main_q.memtoreg;
  assign memwrite_M   = main_v & main_q.memwrite;
  assign ALU_out_M    = main_q.alu;
  assign write_data_M = main_q.wdata;
  assign write_reg_M  = main_q.wreg;

endmodule
